// File: rtl/stuffing_tx.sv
// -----------------------------------------------------------------------------
// stuffing_tx
//
// Transmit-side CAN bit stuffer. It sits between the MACFSM / transmit shift
// register and the bit-timing transmit output. After five consecutive equal
// bits it inserts one complementary stuff bit. While that bit is on the line it
// raises `stuff` so the MACFSM holds its bit source for that step. The `direct`
// input bypasses stuffing for fixed-form fields such as error/overload flags
// and delimiters, and it restarts run counting.
//
// One step is taken per rising edge of `activ`. Holding `activ` high does not
// repeat the step.
//
// Optional feature macro: TXSTUFF_STATCNT_EN
//   When defined, an 8-bit saturating count of inserted stuff bits is exported
//   on `stfcnt`. Only `reset` clears it. When undefined, neither the port nor
//   the counter exists.
// -----------------------------------------------------------------------------
module stuffing_tx (
    input  logic       clock,
    input  logic       reset,
    input  logic       activ,
    input  logic       direct,
    input  logic       bitin,
    output logic       bitout,
    output logic       stuff
`ifdef TXSTUFF_STATCNT_EN
    ,
    output logic [7:0] stfcnt
`endif
);

    // Kind of action taken at this clock edge.
    typedef enum logic [2:0] {
        BR_HOLD    = 3'd0,  // no step: hold everything except the edge flag
        BR_DIRECT  = 3'd1,  // bypass: pass bitin unstuffed, restart run
        BR_STUFF   = 3'd2,  // run of five complete: insert complement bit
        BR_NEW_RUN = 3'd3,  // first bit after reset or a level change
        BR_EXTEND  = 3'd4   // same level as last bit: lengthen the run
    } branch_e;

    // Number of equal bits that triggers a stuff bit.
    localparam logic [2:0] RUN_LIMIT = 3'd5;

    // Registered state
    logic [2:0] r_count;    // equal bits already sent in the current run
    logic       r_buff;     // last bit sent on the line
    logic       r_edged;    // a step was already taken for this activ pulse
    logic       r_bitout;
    logic       r_stuff;
`ifdef TXSTUFF_STATCNT_EN
    logic [7:0] r_stfcnt;
`endif

    // Combinational next-state
    logic       w_step;
    branch_e    w_branch;
    logic [2:0] w_count_nxt;
    logic       w_buff_nxt;
    logic       w_edged_nxt;
    logic       w_bitout_nxt;
    logic       w_stuff_nxt;
`ifdef TXSTUFF_STATCNT_EN
    logic [7:0] w_stfcnt_nxt;
`endif

    // Returns 1 when the run counter shows a run that has reached the limit.
    function automatic logic run_full(input logic [2:0] cnt);
        return (cnt == RUN_LIMIT);
    endfunction

    // Returns 1 when the run counter holds a value that can still be extended.
    // Counter values above the limit cannot occur. If one ever shows up, it is
    // treated as the start of a new run instead of being extended.
    function automatic logic run_extendable(input logic [2:0] cnt);
        return (cnt != 3'd0) && (cnt < RUN_LIMIT);
    endfunction

    // A step is taken only on the first cycle of an activ pulse.
    assign w_step = activ & ~r_edged;

    // Classify this edge into one of the prioritised step actions.
    always_comb begin
        w_branch = BR_HOLD;
        if (!w_step) begin
            w_branch = BR_HOLD;
        end else if (direct) begin
            w_branch = BR_DIRECT;
        end else if (run_full(r_count)) begin
            w_branch = BR_STUFF;
        end else if ((r_count == 3'd0) || (bitin != r_buff)) begin
            w_branch = BR_NEW_RUN;
        end else if (run_extendable(r_count)) begin
            w_branch = BR_EXTEND;
        end else begin
            w_branch = BR_NEW_RUN;
        end
    end

    // Compute the next bit, the run state and the stuff flag for the chosen action.
    always_comb begin
        w_count_nxt  = r_count;
        w_buff_nxt   = r_buff;
        w_bitout_nxt = r_bitout;
        w_stuff_nxt  = r_stuff;
        case (w_branch)
            BR_HOLD: begin
                w_count_nxt  = r_count;
                w_buff_nxt   = r_buff;
                w_bitout_nxt = r_bitout;
                w_stuff_nxt  = r_stuff;
            end
            BR_DIRECT: begin
                w_bitout_nxt = bitin;
                w_buff_nxt   = bitin;
                w_count_nxt  = 3'd1;
                w_stuff_nxt  = 1'b0;
            end
            BR_STUFF: begin
                // The stuff bit itself is the first bit of the next run.
                w_bitout_nxt = ~r_buff;
                w_buff_nxt   = ~r_buff;
                w_count_nxt  = 3'd1;
                w_stuff_nxt  = 1'b1;
            end
            BR_NEW_RUN: begin
                w_bitout_nxt = bitin;
                w_buff_nxt   = bitin;
                w_count_nxt  = 3'd1;
                w_stuff_nxt  = 1'b0;
            end
            BR_EXTEND: begin
                w_bitout_nxt = bitin;
                w_buff_nxt   = r_buff;
                w_count_nxt  = r_count + 3'd1;
                w_stuff_nxt  = 1'b0;
            end
            default: begin
                // Unreachable encoding: restart cleanly with the presented bit.
                w_bitout_nxt = bitin;
                w_buff_nxt   = bitin;
                w_count_nxt  = 3'd1;
                w_stuff_nxt  = 1'b0;
            end
        endcase
    end

    // The edge flag follows activ. It is set by the step and cleared when activ drops.
    always_comb begin
        w_edged_nxt = r_edged;
        if (activ) begin
            w_edged_nxt = 1'b1;
        end else begin
            w_edged_nxt = 1'b0;
        end
    end

`ifdef TXSTUFF_STATCNT_EN
    // Count inserted stuff bits, saturating at the top of the range.
    always_comb begin
        w_stfcnt_nxt = r_stfcnt;
        if ((w_branch == BR_STUFF) && (r_stfcnt != 8'hFF)) begin
            w_stfcnt_nxt = r_stfcnt + 8'd1;
        end else begin
            w_stfcnt_nxt = r_stfcnt;
        end
    end
`endif

    // State and output registers. Reset wins over any step at the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= 3'd0;
            r_buff   <= 1'b1;
            r_edged  <= 1'b0;
            r_bitout <= 1'b1;
            r_stuff  <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_buff   <= w_buff_nxt;
            r_edged  <= w_edged_nxt;
            r_bitout <= w_bitout_nxt;
            r_stuff  <= w_stuff_nxt;
        end
    end

`ifdef TXSTUFF_STATCNT_EN
    // Stuff-bit statistics register. Only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stfcnt <= 8'd0;
        end else begin
            r_stfcnt <= w_stfcnt_nxt;
        end
    end

    assign stfcnt = r_stfcnt;
`endif

    assign bitout = r_bitout;
    assign stuff  = r_stuff;

endmodule

// File: doc/stuffing_tx.md
# stuffing_tx

Transmit-side CAN bit-stuffing unit; it is the counterpart of the receive destuffer. It sits between the MACFSM/transmit shift register and the bit-timing transmit output. After five consecutive equal bits it inserts one complementary stuff bit and signals the MACFSM to hold its bit source for that step. Its `direct` bypass passes fixed-form fields (error/overload flags, delimiters) unstuffed.

## Interface
- No parameters.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high (MACFSM resetstf or global reset).
- `activ`  in  1  MACFSM per-bit step request. One step is taken per rising edge of `activ`; holding it high does not repeat the step.
- `direct`  in  1  MACFSM bypass: pass `bitin` unstuffed and restart run counting.
- `bitin`  in  1  next frame bit from the MACFSM/tx shift register.
- `bitout`  out  1  bit to bit-timing transmit (1 = recessive).
- `stuff`  out  1  current `bitout` is an inserted stuff bit. MACFSM must not advance its shift register for this step.
- `stfcnt`  out  8  inserted-stuff-bit count. Present only with `TXSTUFF_STATCNT_EN`.

## Operation
- Internal state:
  - `count[2:0]`: equal bits already sent in the current run, 0..5.
  - `buff`: last bit sent.
  - `edged`: step-taken flag.
- Reset (`reset`=1 at a clock edge) has priority over everything. It sets `count`=0, `buff`=1, `edged`=0, `bitout`=1, `stuff`=0, `stfcnt`=0.
- `activ`=0: `edged`<=0; all other state is held.
- `activ`=1 with `edged`=1: no step taken; state is held.
- `activ`=1 with `edged`=0: `edged`<=1 and exactly one step is taken. Conditions are evaluated in priority order:
  1. `direct`=1: `bitout`<=`bitin`, `buff`<=`bitin`, `count`<=1, `stuff`<=0. Direct wins even when `count`=5; no stuff bit is inserted.
  2. `count`=5: `bitout`<=~`buff`, `buff`<=~`buff`, `count`<=1, `stuff`<=1. `bitin` is ignored and must be re-presented unchanged at the next step. The stuff bit opens a new run.
  3. `count`=0 or `bitin`!=`buff`: `bitout`<=`bitin`, `buff`<=`bitin`, `count`<=1, `stuff`<=0.
  4. `bitin`=`buff`, `count` in 1..4: `bitout`<=`bitin`, `count`<=`count`+1, `stuff`<=0.
- `count` never exceeds 5, and there is no wrap-around.

## Timing
- Step is detected at the clock edge where `activ`=1 and `edged`=0.
- `bitout`, `stuff`, `stfcnt` are registered and valid one clock after that edge.
- Outputs hold until the next step or reset.
- `stuff` stays high for the whole step in which the stuff bit is on `bitout`. MACFSM samples it before issuing the next `activ` pulse.
- `activ` high for N cycles produces one step. `activ` must return low for at least one clock between steps.
- Reset asserted together with `activ` rising: reset wins and no step is taken. The first step after reset behaves as `count`=0.
- `direct` and `bitin` are sampled only at the step edge.

## Configuration
- `TXSTUFF_STATCNT_EN` defined:
  - `stfcnt[7:0]` port exists.
  - It increments by 1 on every step taking branch 2 and saturates at 255.
  - It is cleared only by `reset`.
- Undefined: no `stfcnt` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset then 5 steps `bitin`=0, then 2 steps `bitin`=0 (held) -> `bitout` 0,0,0,0,0,1,0 and `stuff` high only on step 6.
- After reset, 5×0, stuff, then `bitin`=1 for 4 steps, then 1 held -> `bitout` ...1(stuff),1,1,1,1,0(stuff=1). This checks that the stuff bit starts the new run.
- Alternating 0/1 for 20 steps -> `bitout`=`bitin` each step, `stuff` never asserted.
- 5×1 then `direct`=1 with `bitin`=1 for 6 steps (error-flag style) -> six 1s out, `stuff`=0. Then `direct`=0 with 1 -> run counting restarts, so the stuff bit occurs only after 5 total equal bits.
- `activ` held high 10 cycles -> exactly one step. `reset` pulsed mid-run (`count`=3) -> `bitout`=1, `stuff`=0, next 5 equal bits are not stuffed early.
- With `TXSTUFF_STATCNT_EN`: 300 stuff insertions -> `stfcnt`=255. Reset -> 0.
